// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word-aligned memory reads, pairs
// returned words with their PCs, and flushes stale responses after a redirect.
module fetch_unit #(
    parameter int                 Width          = 32,
    parameter logic [Width-1:0]   BootAddr       = '0,
    parameter int                 MaxOutstanding = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             redirect_valid_i,
    input  logic [Width-1:0] redirect_pc_i,
    output logic             mem_req_valid_o,
    output logic [Width-1:0] mem_req_addr_o,
    input  logic             mem_req_ready_i,
    input  logic             mem_rsp_valid_i,
    input  logic [Width-1:0] mem_rsp_data_i,
    output logic             mem_rsp_ready_o,
    output logic             instr_valid_o,
    output logic [Width-1:0] instr_data_o,
    output logic [Width-1:0] instr_pc_o,
    input  logic             instr_ready_i
);

    localparam int            CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

    logic [Width-1:0] req_pc_q;
    logic [Width-1:0] rsp_pc_q;
    logic [CntW-1:0]  outstanding_q;
    logic [CntW-1:0]  discard_q;

    logic             discarding;
    logic             req_fire;
    logic             rsp_fire;
    logic [Width-1:0] redirect_target;

    // A redirect cycle behaves like discard mode so a response landing on it is dropped.
    assign discarding      = (discard_q != '0) || redirect_valid_i;
    assign redirect_target = redirect_pc_i & ~Width'(3);

    assign mem_req_valid_o = rst_ni && !redirect_valid_i && (outstanding_q < MaxOut);
    assign mem_req_addr_o  = rst_ni ? req_pc_q : BootAddr;
    assign mem_rsp_ready_o = rst_ni && (discarding || instr_ready_i);
    assign instr_valid_o   = rst_ni && !discarding && mem_rsp_valid_i;
    assign instr_data_o    = rst_ni ? mem_rsp_data_i : '0;
    assign instr_pc_o      = rst_ni ? rsp_pc_q : BootAddr;

    assign req_fire = mem_req_valid_o && mem_req_ready_i;
    assign rsp_fire = mem_rsp_valid_i && mem_rsp_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_pc_q      <= BootAddr;
            rsp_pc_q      <= BootAddr;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (redirect_valid_i) begin
            // Everything still in flight belongs to the old path.
            req_pc_q      <= redirect_target;
            rsp_pc_q      <= redirect_target;
            outstanding_q <= outstanding_q - CntW'(rsp_fire);
            discard_q     <= outstanding_q - CntW'(rsp_fire);
        end else begin
            if (req_fire) begin
                req_pc_q <= req_pc_q + Width'(4);
            end
            if (rsp_fire) begin
                if (discard_q != '0) begin
                    discard_q <= discard_q - CntW'(1);
                end else begin
                    rsp_pc_q <= rsp_pc_q + Width'(4);
                end
            end
            outstanding_q <= outstanding_q + CntW'(req_fire) - CntW'(rsp_fire);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(mem_rsp_valid_i && (outstanding_q == '0)));

endmodule
